// File: rtl/data_memory_responder.sv
// Data-memory responder: takes one-cycle read/write strobes and waits a fixed number
// of cycles. It then accesses an internal word array and returns a one-cycle ready pulse.
module data_memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_memory_read,
    input  logic                  data_memory_write,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    op_write;
    logic                    op_err;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    strobe;
    logic                    access;

    function automatic logic request_error(input logic [31:0] addr, input logic rd, input logic wr);
        return (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0) || (rd && wr);
    endfunction

    assign strobe = data_memory_read | data_memory_write;
    assign access = (state == WAIT) && (cnt == 4'd0);

    // Request payload is plain data: captured in IDLE, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && strobe) begin
            idx   <= address[ADDR_WIDTH+1:2];
            wdata <= write_data;
        end
    end

    // Gating with rst_n drops a write whose access edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && access && op_write && !op_err) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_write  <= 1'b0;
            op_err    <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        op_write <= data_memory_write;
                        op_err   <= request_error(address, data_memory_read, data_memory_write);
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ready <= 1'b1;
                        error <= op_err;
                        if (op_err) begin
                            read_data <= '0;
                        end else if (!op_write) begin
                            read_data <= mem[idx];
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: instance 0 uses WAIT_CYCLES=1 and instance 1 uses
// WAIT_CYCLES=3. Both are checked against a word-array model with random traffic.
module tb_data_memory_responder;

    logic        clk;
    logic        rst_n;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdat   [2];
    logic        rdy    [2];
    logic        er     [2];

    int unsigned checks;
    int unsigned passed;

    logic [31:0] mem_m   [2][64];
    logic [31:0] last_rd [2];

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .data_memory_read(rd_s[0]), .data_memory_write(wr_s[0]),
        .address(addr_s[0]), .write_data(wd_s[0]),
        .read_data(rdat[0]), .ready(rdy[0]), .error(er[0])
    );

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .data_memory_read(rd_s[1]), .data_memory_write(wr_s[1]),
        .address(addr_s[1]), .write_data(wd_s[1]),
        .read_data(rdat[1]), .ready(rdy[1]), .error(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // One request on instance i. It checks latency, error, read_data and the one-cycle pulse.
    task automatic req(input int i, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input string name);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          n;
        bit          got;
        exp_err = (a % 4 != 0) || (a >= 32'd256) || (r && w);
        if (exp_err)      exp_rd = 32'd0;
        else if (r)       exp_rd = mem_m[i][a / 4];
        else              exp_rd = last_rd[i];
        rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wd_s[i] = d;
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); n++;
            @(negedge clk);
            rd_s[i] = 1'b0; wr_s[i] = 1'b0;
            if (rdy[i] === 1'b1) got = 1;
        end
        checks++;
        if (n !== wait_of(i) + 1 || !got)
            $display("FAIL %s latency: got %0d cycles (ready seen=%0d), expected %0d", name, n, got, wait_of(i) + 1);
        else passed++;
        checks++;
        if (er[i] !== exp_err)
            $display("FAIL %s error: got %b, expected %b", name, er[i], exp_err);
        else passed++;
        checks++;
        if (rdat[i] !== exp_rd)
            $display("FAIL %s read_data: got %h, expected %h", name, rdat[i], exp_rd);
        else passed++;
        @(posedge clk); @(negedge clk);
        checks++;
        if (rdy[i] !== 1'b0 || er[i] !== 1'b0)
            $display("FAIL %s pulse width: ready=%b error=%b after response, expected 0/0", name, rdy[i], er[i]);
        else passed++;
        if (!exp_err) begin
            if (w) mem_m[i][a / 4] = d;
            else   last_rd[i] = exp_rd;
        end else begin
            last_rd[i] = 32'd0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 0; wr_s[i] = 0; addr_s[i] = 0; wd_s[i] = 0; last_rd[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdy[i] !== 1'b0 || er[i] !== 1'b0 || rdat[i] !== 32'd0)
                $display("FAIL reset_state[%0d]: ready=%b error=%b read_data=%h, expected 0/0/0", i, rdy[i], er[i], rdat[i]);
            else passed++;
        end
    endtask

    // Clear the model's view: write a known value to every word of both arrays.
    task automatic init_arrays;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++)
                req(i, 0, 1, k * 4, 32'hA5000000 + k * 3 + i, "init");
    endtask

    task automatic test_reset_mid_write;
        req(0, 0, 1, 32'h8, 32'h11111111, "rst_prep_wr");
        req(0, 1, 0, 32'h8, 32'h0, "rst_prep_rd");
        rd_s[0] = 0; wr_s[0] = 1; addr_s[0] = 32'h8; wd_s[0] = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        wr_s[0] = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b0 || er[0] !== 1'b0 || rdat[0] !== 32'd0)
            $display("FAIL async_reset: ready=%b error=%b read_data=%h, expected 0/0/0", rdy[0], er[0], rdat[0]);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 0; last_rd[1] = 0;
        @(negedge clk);
        req(0, 1, 0, 32'h8, 32'h0, "abandoned_write_read");
    endtask

    task automatic test_write_read;
        req(0, 0, 1, 32'h10, 32'h12345678, "wr_0x10");
        req(0, 1, 0, 32'h10, 32'h0, "rd_0x10");
    endtask

    task automatic test_errors;
        req(0, 1, 0, 32'h6, 32'h0, "misaligned_rd");
        req(0, 0, 1, 32'h100, 32'hCAFEF00D, "out_of_range_wr");
        req(0, 1, 0, 32'h0, 32'h0, "rd_0x0_after_oor");
        req(0, 1, 1, 32'h4, 32'hBADBAD00, "dual_strobe");
        req(0, 1, 0, 32'h4, 32'h0, "rd_0x4_after_dual");
        req(1, 0, 1, 32'h8000_0000, 32'h1, "high_bit_wr");
        req(1, 1, 0, 32'h0, 32'h0, "rd_0x0_after_high");
    endtask

    task automatic test_ignore_latency;
        int first;
        int pulses;
        req(1, 0, 1, 32'h24, 32'h0A0A0A0A, "ign_prep");
        rd_s[1] = 0; wr_s[1] = 1; addr_s[1] = 32'h20; wd_s[1] = 32'h55AA55AA;
        first = 0; pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            wr_s[1] = (c == 1 || c == 2);
            addr_s[1] = 32'h24; wd_s[1] = 32'hFFFF0000;
            if (rdy[1] === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        wr_s[1] = 0;
        checks++;
        if (first !== 4)
            $display("FAIL ignore_latency: ready first seen %0d cycles after request, expected 4", first);
        else passed++;
        checks++;
        if (pulses !== 1)
            $display("FAIL ignore_pulses: got %0d ready pulses, expected 1", pulses);
        else passed++;
        mem_m[1][32'h20 / 4] = 32'h55AA55AA;
        req(1, 1, 0, 32'h24, 32'h0, "ignored_write_rd");
        req(1, 1, 0, 32'h20, 32'h0, "accepted_write_rd");
    endtask

    task automatic test_random;
        int          i;
        int          kind;
        bit          r;
        bit          w;
        logic [31:0] a;
        for (int t = 0; t < 60; t++) begin
            i    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, 63) * 4;
            r    = $urandom_range(0, 1);
            w    = !r;
            if (kind == 7) a = a | $urandom_range(1, 3);
            if (kind == 8) a = a | ($urandom_range(1, 255) << 8);
            if (kind == 9) begin r = 1; w = 1; end
            req(i, r, w, a, $urandom, "random");
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        init_arrays();
        test_reset_mid_write();
        test_write_read();
        test_errors();
        test_ignore_latency();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
